// File: rtl/gb_int_ctrl.sv
// -----------------------------------------------------------------------------
// gb_int_ctrl
//
// Game Boy style interrupt controller. It holds the IF/IE registers and the
// interrupt master enable (IME) with the one-instruction EI delay, and it
// implements HALT (including wake-up and the HALT bug). It also sequences the
// 5 M-cycle interrupt dispatch for the CPU scheduler.
//
// Ports
//   clk                : M-cycle clock, all state updates on posedge
//   reset              : asynchronous, active-high system reset
//   irq_i[4:0]         : request pulses (VBlank, STAT, Timer, Serial, Joypad)
//   reg_wr_i           : register write strobe
//   reg_sel_i          : 0 = IF (0xFF0F), 1 = IE (0xFFFF)
//   reg_wdata_i[7:0]   : register write data
//   reg_rdata_o[7:0]   : combinational read of the selected register
//   ei_i/di_i/reti_i/halt_i : single-cycle instruction decoder strobes
//   instr_boundary_i   : CPU is on the last M-cycle of an instruction
//   ime_o              : interrupt master enable
//   halted_o           : controller is in the HALTED state
//   wake_o             : one-cycle pulse when a pending interrupt ends HALT
//   halt_bug_o         : one-cycle pulse when HALT triggers the HALT bug
//   dispatch_o         : dispatch sequence in progress
//   dispatch_mcycle_o  : current dispatch M-cycle (0..4), 0 when idle
//   vector_o[15:0]     : resolved vector during M3/M4, 0x0000 otherwise
// -----------------------------------------------------------------------------
module gb_int_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  irq_i,
    input  logic        reg_wr_i,
    input  logic        reg_sel_i,
    input  logic [7:0]  reg_wdata_i,
    output logic [7:0]  reg_rdata_o,
    input  logic        ei_i,
    input  logic        di_i,
    input  logic        reti_i,
    input  logic        halt_i,
    input  logic        instr_boundary_i,
    output logic        ime_o,
    output logic        halted_o,
    output logic        wake_o,
    output logic        halt_bug_o,
    output logic        dispatch_o,
    output logic [2:0]  dispatch_mcycle_o,
    output logic [15:0] vector_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HALTED   = 2'd1,
        ST_DISPATCH = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [4:0]  if_r;
    logic [7:0]  ie_r;
    logic        ime_r;
    logic        ime_pending_r;
    logic [15:0] vector_r;
    logic        wake_r;
    logic        halt_bug_r;

    logic [4:0]  pending_s;
    logic        m3_s;
    logic [15:0] vec_s;
    logic [4:0]  clr_mask_s;
    logic [4:0]  if_next_s;
    logic        dispatch_start_s;
    logic        ime_next_s;
    logic        ime_pending_next_s;

    // Index of the highest-priority (lowest-numbered) set request bit.
    function automatic logic [2:0] lowest_index(input logic [4:0] req);
        logic [2:0] idx;
        casez (req)
            5'b????1: idx = 3'd0;
            5'b???10: idx = 3'd1;
            5'b??100: idx = 3'd2;
            5'b?1000: idx = 3'd3;
            5'b10000: idx = 3'd4;
            default:  idx = 3'd0;
        endcase
        return idx;
    endfunction

    // Vector for the winning request; 0x0000 when nothing is pending.
    function automatic logic [15:0] vector_for(input logic [4:0] req);
        logic [15:0] vec;
        if (req == 5'd0) begin
            vec = 16'h0000;
        end else begin
            vec = 16'h0040 + {10'd0, lowest_index(req), 3'd0};
        end
        return vec;
    endfunction

    assign pending_s = ie_r[4:0] & if_r;
    assign m3_s      = (state_r == ST_DISPATCH) && (cnt_r == 3'd3);
    assign vec_s     = vector_for(pending_s);

    // IF bit to acknowledge at M3; nothing is cleared if IE was rewritten to hide it.
    always_comb begin
        clr_mask_s = 5'd0;
        if (m3_s && (pending_s != 5'd0)) begin
            clr_mask_s = 5'b00001 << lowest_index(pending_s);
        end else begin
            clr_mask_s = 5'd0;
        end
    end

    // Next IF: a CPU write replaces the value; new requests always OR on top.
    always_comb begin
        if_next_s = if_r;
        if (reg_wr_i && !reg_sel_i) begin
            if_next_s = reg_wdata_i[4:0] | irq_i;
        end else begin
            if_next_s = (if_r & ~clr_mask_s) | irq_i;
        end
    end

    // Dispatch begins from an instruction boundary or directly out of HALT.
    always_comb begin
        dispatch_start_s = 1'b0;
        if ((state_r == ST_IDLE) && instr_boundary_i && ime_r && (pending_s != 5'd0)) begin
            dispatch_start_s = 1'b1;
        end else if ((state_r == ST_HALTED) && ime_r && (pending_s != 5'd0)) begin
            dispatch_start_s = 1'b1;
        end else begin
            dispatch_start_s = 1'b0;
        end
    end

    // IME / EI-delay update; DI and dispatch entry override everything else.
    always_comb begin
        ime_next_s         = ime_r;
        ime_pending_next_s = ime_pending_r;
        if (di_i || dispatch_start_s) begin
            ime_next_s         = 1'b0;
            ime_pending_next_s = 1'b0;
        end else begin
            if (reti_i) begin
                ime_next_s = 1'b1;
            end else begin
                ime_next_s = ime_r;
            end
            if (state_r != ST_DISPATCH) begin
                // The registered IME is what the dispatch check sees this cycle,
                // so the instruction after EI still runs before any interrupt.
                if (instr_boundary_i && ime_pending_r) begin
                    ime_next_s         = 1'b1;
                    ime_pending_next_s = 1'b0;
                end else begin
                    ime_pending_next_s = ime_pending_r;
                end
                if (ei_i) begin
                    ime_pending_next_s = 1'b1;
                end else begin
                    ime_pending_next_s = ime_pending_next_s;
                end
            end else begin
                ime_pending_next_s = ime_pending_r;
            end
        end
    end

    // IF / IE register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_r <= 5'd0;
            ie_r <= 8'd0;
        end else begin
            if_r <= if_next_s;
            if (reg_wr_i && reg_sel_i) begin
                ie_r <= reg_wdata_i;
            end
        end
    end

    // Control FSM: IDLE / HALTED / DISPATCH with IME and registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 3'd0;
            ime_r         <= 1'b0;
            ime_pending_r <= 1'b0;
            vector_r      <= 16'h0000;
            wake_r        <= 1'b0;
            halt_bug_r    <= 1'b0;
        end else begin
            ime_r         <= ime_next_s;
            ime_pending_r <= ime_pending_next_s;
            wake_r        <= 1'b0;
            halt_bug_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 3'd0;
                    if (dispatch_start_s) begin
                        state_r <= ST_DISPATCH;
                    end else if (halt_i) begin
                        // HALT with IME off and an interrupt already pending
                        // does not halt; the CPU re-reads the next byte instead.
                        if (!ime_r && (pending_s != 5'd0)) begin
                            halt_bug_r <= 1'b1;
                        end else begin
                            state_r <= ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    cnt_r <= 3'd0;
                    if (pending_s != 5'd0) begin
                        wake_r <= 1'b1;
                        if (ime_r) begin
                            state_r <= ST_DISPATCH;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_DISPATCH: begin
                    if (cnt_r == 3'd4) begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= 3'd0;
                        vector_r <= 16'h0000;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                        if (cnt_r == 3'd3) begin
                            vector_r <= vec_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

    // Output decode; vector is resolved live at M3 and held from the register at M4.
    always_comb begin
        reg_rdata_o       = reg_sel_i ? ie_r : {3'b111, if_r};
        ime_o             = ime_r;
        halted_o          = (state_r == ST_HALTED);
        wake_o            = wake_r;
        halt_bug_o        = halt_bug_r;
        dispatch_o        = (state_r == ST_DISPATCH);
        dispatch_mcycle_o = (state_r == ST_DISPATCH) ? cnt_r : 3'd0;
        if (m3_s) begin
            vector_o = vec_s;
        end else if ((state_r == ST_DISPATCH) && (cnt_r == 3'd4)) begin
            vector_o = vector_r;
        end else begin
            vector_o = 16'h0000;
        end
    end

endmodule

// File: tb/tb_gb_int_ctrl.sv
// Directed testbench for gb_int_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled in the same window.
module tb_gb_int_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  irq_i;
    logic        reg_wr_i;
    logic        reg_sel_i;
    logic [7:0]  reg_wdata_i;
    logic [7:0]  reg_rdata_o;
    logic        ei_i, di_i, reti_i, halt_i, instr_boundary_i;
    logic        ime_o, halted_o, wake_o, halt_bug_o, dispatch_o;
    logic [2:0]  dispatch_mcycle_o;
    logic [15:0] vector_o;

    int n_cmp;
    int n_bad;

    gb_int_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .irq_i             (irq_i),
        .reg_wr_i          (reg_wr_i),
        .reg_sel_i         (reg_sel_i),
        .reg_wdata_i       (reg_wdata_i),
        .reg_rdata_o       (reg_rdata_o),
        .ei_i              (ei_i),
        .di_i              (di_i),
        .reti_i            (reti_i),
        .halt_i            (halt_i),
        .instr_boundary_i  (instr_boundary_i),
        .ime_o             (ime_o),
        .halted_o          (halted_o),
        .wake_o            (wake_o),
        .halt_bug_o        (halt_bug_o),
        .dispatch_o        (dispatch_o),
        .dispatch_mcycle_o (dispatch_mcycle_o),
        .vector_o          (vector_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic sel, input logic [7:0] data);
        reg_wr_i    = 1'b1;
        reg_sel_i   = sel;
        reg_wdata_i = data;
        tick();
        reg_wr_i    = 1'b0;
        reg_wdata_i = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reg_sel_i = 1'b0;
        #1;
        n_cmp++;
        if ({ime_o, halted_o, wake_o, halt_bug_o, dispatch_o} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 00000", {ime_o, halted_o, wake_o, halt_bug_o, dispatch_o});
        end
        n_cmp++;
        if (vector_o !== 16'h0000 || dispatch_mcycle_o !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_vec got %h/%0d want 0000/0", vector_o, dispatch_mcycle_o);
        end
        n_cmp++;
        if (reg_rdata_o !== 8'hE0) begin
            n_bad++;
            $display("FAIL reset_if got %h want e0", reg_rdata_o);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_dispatch();
        logic [15:0] exp_vec;
        wr_reg(1'b1, 8'h05);
        wr_reg(1'b0, 8'h05);
        reti_i = 1'b1;
        tick();
        reti_i = 1'b0;
        n_cmp++;
        if (ime_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reti_ime got %b want 1", ime_o);
        end
        instr_boundary_i = 1'b1;
        tick();
        instr_boundary_i = 1'b0;
        n_cmp++;
        if (ime_o !== 1'b0) begin
            n_bad++;
            $display("FAIL disp_ime_clr got %b want 0", ime_o);
        end
        for (int k = 0; k < 5; k++) begin
            exp_vec = (k >= 3) ? 16'h0040 : 16'h0000;
            n_cmp++;
            if (dispatch_o !== 1'b1 || dispatch_mcycle_o !== 3'(k) || vector_o !== exp_vec) begin
                n_bad++;
                $display("FAIL disp_m%0d got d=%b m=%0d v=%h want d=1 m=%0d v=%h",
                         k, dispatch_o, dispatch_mcycle_o, vector_o, k, exp_vec);
            end
            tick();
        end
        reg_sel_i = 1'b0;
        #1;
        n_cmp++;
        if (dispatch_o !== 1'b0 || vector_o !== 16'h0000 || dispatch_mcycle_o !== 3'd0) begin
            n_bad++;
            $display("FAIL disp_end got d=%b v=%h m=%0d want 0/0000/0", dispatch_o, vector_o, dispatch_mcycle_o);
        end
        n_cmp++;
        if (reg_rdata_o !== 8'hE4) begin
            n_bad++;
            $display("FAIL disp_if got %h want e4", reg_rdata_o);
        end
    endtask

    task automatic test_ei_delay();
        wr_reg(1'b0, 8'h00);
        wr_reg(1'b1, 8'h04);
        ei_i  = 1'b1;
        irq_i = 5'b00100;
        tick();
        ei_i  = 1'b0;
        irq_i = 5'b00000;
        n_cmp++;
        if (ime_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ei_early got %b want 0", ime_o);
        end
        instr_boundary_i = 1'b1;
        tick();
        n_cmp++;
        if (dispatch_o !== 1'b0 || ime_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ei_b1 got d=%b ime=%b want d=0 ime=1", dispatch_o, ime_o);
        end
        tick();
        instr_boundary_i = 1'b0;
        n_cmp++;
        if (dispatch_o !== 1'b1 || dispatch_mcycle_o !== 3'd0) begin
            n_bad++;
            $display("FAIL ei_b2 got d=%b m=%0d want 1/0", dispatch_o, dispatch_mcycle_o);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (dispatch_mcycle_o !== 3'd3 || vector_o !== 16'h0050) begin
            n_bad++;
            $display("FAIL ei_vec got m=%0d v=%h want 3/0050", dispatch_mcycle_o, vector_o);
        end
        tick(); tick();
        reg_sel_i = 1'b0;
        #1;
        n_cmp++;
        if (reg_rdata_o !== 8'hE0 || dispatch_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ei_if got %h d=%b want e0 d=0", reg_rdata_o, dispatch_o);
        end
    endtask

    task automatic test_ie_overwrite();
        reti_i = 1'b1;
        tick();
        reti_i = 1'b0;
        wr_reg(1'b1, 8'h01);
        wr_reg(1'b0, 8'h01);
        instr_boundary_i = 1'b1;
        tick();
        instr_boundary_i = 1'b0;
        tick(); tick();
        n_cmp++;
        if (dispatch_mcycle_o !== 3'd2) begin
            n_bad++;
            $display("FAIL ovr_m2 got %0d want 2", dispatch_mcycle_o);
        end
        wr_reg(1'b1, 8'h00);
        n_cmp++;
        if (dispatch_mcycle_o !== 3'd3 || vector_o !== 16'h0000) begin
            n_bad++;
            $display("FAIL ovr_m3 got m=%0d v=%h want 3/0000", dispatch_mcycle_o, vector_o);
        end
        tick();
        n_cmp++;
        if (dispatch_mcycle_o !== 3'd4 || vector_o !== 16'h0000) begin
            n_bad++;
            $display("FAIL ovr_m4 got m=%0d v=%h want 4/0000", dispatch_mcycle_o, vector_o);
        end
        tick();
        reg_sel_i = 1'b0;
        #1;
        n_cmp++;
        if (reg_rdata_o !== 8'hE1 || ime_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_if got %h ime=%b want e1 ime=0", reg_rdata_o, ime_o);
        end
    endtask

    task automatic test_halt();
        wr_reg(1'b1, 8'h10);
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (halted_o !== 1'b1 || wake_o !== 1'b0) begin
                n_bad++;
                $display("FAIL halt_hold%0d got h=%b w=%b want 1/0", k, halted_o, wake_o);
            end
            tick();
        end
        irq_i = 5'b10000;
        tick();
        irq_i = 5'b00000;
        n_cmp++;
        if (halted_o !== 1'b1 || wake_o !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_irq got h=%b w=%b want 1/0", halted_o, wake_o);
        end
        tick();
        n_cmp++;
        if (wake_o !== 1'b1 || halted_o !== 1'b0 || dispatch_o !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_wake got w=%b h=%b d=%b want 1/0/0", wake_o, halted_o, dispatch_o);
        end
        tick();
        n_cmp++;
        if (wake_o !== 1'b0 || dispatch_o !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_wake_end got w=%b d=%b want 0/0", wake_o, dispatch_o);
        end
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        n_cmp++;
        if (halt_bug_o !== 1'b1 || halted_o !== 1'b0) begin
            n_bad++;
            $display("FAIL haltbug got b=%b h=%b want 1/0", halt_bug_o, halted_o);
        end
        tick();
        n_cmp++;
        if (halt_bug_o !== 1'b0 || halted_o !== 1'b0) begin
            n_bad++;
            $display("FAIL haltbug_end got b=%b h=%b want 0/0", halt_bug_o, halted_o);
        end
    endtask

    task automatic test_reset_mid();
        reti_i = 1'b1;
        tick();
        reti_i = 1'b0;
        wr_reg(1'b1, 8'h01);
        wr_reg(1'b0, 8'h01);
        instr_boundary_i = 1'b1;
        tick();
        instr_boundary_i = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (dispatch_mcycle_o !== 3'd3) begin
            n_bad++;
            $display("FAIL rstm_m3 got %0d want 3", dispatch_mcycle_o);
        end
        reset     = 1'b1;
        reg_sel_i = 1'b1;
        #1;
        n_cmp++;
        if (dispatch_o !== 1'b0 || ime_o !== 1'b0 || vector_o !== 16'h0000 || reg_rdata_o !== 8'h00) begin
            n_bad++;
            $display("FAIL rstm_state got d=%b ime=%b v=%h ie=%h want 0/0/0000/00",
                     dispatch_o, ime_o, vector_o, reg_rdata_o);
        end
        reg_sel_i = 1'b0;
        #1;
        n_cmp++;
        if (reg_rdata_o !== 8'hE0) begin
            n_bad++;
            $display("FAIL rstm_if got %h want e0", reg_rdata_o);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ei_di();
        ei_i = 1'b1;
        di_i = 1'b1;
        tick();
        ei_i = 1'b0;
        di_i = 1'b0;
        instr_boundary_i = 1'b1;
        tick();
        instr_boundary_i = 1'b0;
        tick();
        n_cmp++;
        if (ime_o !== 1'b0) begin
            n_bad++;
            $display("FAIL eidi got %b want 0", ime_o);
        end
        // A request arriving with an IF write is merged into the written value.
        irq_i = 5'b01000;
        wr_reg(1'b0, 8'h02);
        irq_i = 5'b00000;
        reg_sel_i = 1'b0;
        #1;
        n_cmp++;
        if (reg_rdata_o !== 8'hEA) begin
            n_bad++;
            $display("FAIL if_or got %h want ea", reg_rdata_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        irq_i = 5'b00000;
        reg_wr_i = 1'b0;
        reg_sel_i = 1'b0;
        reg_wdata_i = 8'h00;
        ei_i = 1'b0;
        di_i = 1'b0;
        reti_i = 1'b0;
        halt_i = 1'b0;
        instr_boundary_i = 1'b0;
        test_reset();
        test_dispatch();
        test_ei_delay();
        test_ie_overwrite();
        test_halt();
        test_reset_mid();
        test_ei_di();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gb_int_ctrl.md
GB_INT_CTRL -- requirements
Module: gb_int_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  machine (M) clock; all state updates on posedge.
REQ-002 SHALL provide: reset  in  1  system reset, asynchronous, active-high.
REQ-003 SHALL provide: irq_i  in  5  interrupt request pulses: bit0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
REQ-004 SHALL provide: reg_wr_i  in  1 / reg_sel_i  in  1 (0=IF 0xFF0F, 1=IE 0xFFFF) / reg_wdata_i  in  8  register write port.
REQ-005 SHALL provide: reg_rdata_o  out  8  combinational read of the register selected by reg_sel_i.
REQ-006 SHALL provide: ei_i, di_i, reti_i, halt_i  in  1 each  single-cycle decoder strobes.
REQ-007 SHALL provide: instr_boundary_i  in  1  CPU is at an instruction boundary (last M-cycle, next opcode being fetched).
REQ-008 SHALL provide: ime_o  out  1  interrupt master enable.
REQ-009 SHALL provide: halted_o, wake_o, halt_bug_o  out  1 each  halt state, wake pulse, HALT-bug pulse.
REQ-010 SHALL provide: dispatch_o  out  1 / dispatch_mcycle_o  out  3 / vector_o  out  16  dispatch sequencing to the CPU scheduler.

Function
REQ-011 SHALL hold IF[4:0], IE[7:0], IME, ime_pending, state in {IDLE, HALTED, DISPATCH}, 3-bit dispatch counter.
REQ-012 SHALL define pending[4:0] = IE[4:0] & IF[4:0].
REQ-013 SHALL read IF as {3'b111, IF[4:0]}, IE as all 8 bits.
REQ-014 SHALL set IF[n] on irq_i[n]=1; on same-cycle IF write, irq_i bits OR over the written value.
REQ-015 ei_i SHALL set ime_pending; IME becomes 1 at the next instr_boundary_i; the dispatch check at that same boundary uses the pre-update IME (one instruction executes after EI).
REQ-016 di_i SHALL clear IME and ime_pending next edge; di_i beats ei_i if same cycle.
REQ-017 reti_i SHALL set IME next edge, no delay.
REQ-018 In IDLE, instr_boundary_i & IME & pending!=0 SHALL enter DISPATCH at counter 0 and clear IME, ime_pending.
REQ-019 halt_i in IDLE: IME=0 & pending!=0 -> halt_bug_o 1-cycle pulse, stay IDLE; else enter HALTED.
REQ-020 In HALTED, pending!=0 SHALL pulse wake_o one cycle; IME=1 -> DISPATCH counter 0; IME=0 -> IDLE (no dispatch, IF untouched).
REQ-021 DISPATCH SHALL last exactly 5 M-cycles, dispatch_mcycle_o=0..4, dispatch_o=1 throughout: M0,M1 idle/PC-decrement; M2 push PCH; M3 push PCL and vector resolve; M4 PC load; then IDLE.
REQ-022 At M3 SHALL select the lowest-index set pending bit n, latch vector 0x0040+8n, clear IF[n] next edge (same-cycle irq_i[n] re-sets it).
REQ-023 If pending==0 at M3 (IE overwritten during push), SHALL latch vector 0x0000 and clear no IF bit.
REQ-024 vector_o SHALL be valid M3-M4, 0x0000 otherwise; dispatch_mcycle_o=0 outside DISPATCH.
REQ-025 instr_boundary_i, ei_i, halt_i SHALL be ignored while in DISPATCH; irq_i and register writes remain live.
REQ-026 halted_o SHALL be 1 exactly when state==HALTED.

Reset
REQ-027 reset SHALL asynchronously force IF=0, IE=0, IME=0, ime_pending=0, state IDLE, counter 0.
REQ-028 During reset all outputs SHALL be 0 except reg_rdata_o (IF reads 0xE0).
REQ-029 reset mid-DISPATCH or HALTED SHALL abort to IDLE with no IF clear.

Verification
REQ-030 IE=0x05, IF write 0x05, IME=1, boundary -> DISPATCH 5 cycles, vector_o=0x0040, IF reads 0xE4.
REQ-031 ei_i, irq_i[2] with IE=0x04, boundary#1 -> no dispatch, ime_o=1; boundary#2 -> dispatch, vector 0x0050.
REQ-032 IME=1, IE=0x01, IF=0x01, write IE=0x00 at M2 -> vector_o=0x0000 at M3, IF still 0xE1.
REQ-033 IME=0, IE=0x10, halt_i, 3 idle cycles, irq_i[4] -> wake_o pulse, IDLE, no dispatch; repeat with IF already 0x10 -> halt_bug_o pulse, never HALTED.
REQ-034 reset asserted at M3 -> immediate IDLE, ime_o=0, IE reads 0x00, IF reads 0xE0.
REQ-035 ei_i and di_i same cycle, then boundary -> ime_o stays 0.
